ym_bus_sequencer: RTL and testbench

YM_BUS_SEQUENCER -- requirements
Module: ym_bus_sequencer

---
 rtl/ym_bus_sequencer_if.sv | 43 ++++
 rtl/ym_bus_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_ym_bus_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ym_bus_sequencer_if.sv
// Bus bundle between the two write requesters and the YM bus sequencer.
//
// Handshake: a requester holds rN_valid together with stable rN_chip,
// rN_addr and rN_data. The transfer is accepted on the rising cpu_clock
// edge where both rN_valid and rN_ready are high. rN_ready is only ever high
// while the sequencer is idle, and at most one of r0_ready / r1_ready is high
// at a time. Nothing is latched from a requester unless it is accepted.
interface ym_bus_sequencer_if;
  logic       r0_valid;
  logic       r1_valid;
  logic       r0_chip;
  logic       r1_chip;
  logic [3:0] r0_addr;
  logic [3:0] r1_addr;
  logic [7:0] r0_data;
  logic [7:0] r1_data;
  logic       r0_ready;
  logic       r1_ready;
  logic       flush;
  logic       bdir;
  logic       bc1;
  logic       ym_sel;
  logic [7:0] ym_da;
  logic       da_oe;
  logic       busy;
  logic [2:0] dbg_state;

  // Requester side: drives requests and flush, observes the YM bus.
  modport master (
    output r0_valid, r1_valid, r0_chip, r1_chip, r0_addr, r1_addr,
           r0_data, r1_data, flush,
    input  r0_ready, r1_ready, bdir, bc1, ym_sel, ym_da, da_oe, busy,
           dbg_state
  );

  // Sequencer side.
  modport slave (
    input  r0_valid, r1_valid, r0_chip, r1_chip, r0_addr, r1_addr,
           r0_data, r1_data, flush,
    output r0_ready, r1_ready, bdir, bc1, ym_sel, ym_da, da_oe, busy,
           dbg_state
  );
endinterface

// File: rtl/ym_bus_sequencer.sv
// YM register write sequencer: arbitrates two requesters round-robin and
// plays each write onto the YM bus as an address phase and a data phase,
// skipping the address phase when the chip/register was the last one
// addressed (address cache).
module ym_bus_sequencer #(
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic                cpu_clock,
  input  logic                reset,
  ym_bus_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_GAP1 = 3'd2,
    S_DATA = 3'd3,
    S_GAP2 = 3'd4
  } state_t;

  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_addr;
  logic [7:0]  r_data;
  logic        r_last_grant;
  logic        r_cache_valid;
  logic        r_cache_chip;
  logic [3:0]  r_cache_addr;
  logic        r_bdir;
  logic        r_bc1;
  logic [7:0]  r_da;
  logic        r_oe;
  logic        r_sel;
  logic        r_busy;

  logic        w_idle;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_chip;
  logic [3:0]  w_addr;
  logic [7:0]  w_data;
  logic        w_hit;
  logic        w_cnt_done;
  logic        w_cache_load;

  // Ready is a function of the registered state plus the live valids so a
  // valid that drops before acceptance leaves no trace; reset forces it low.
  assign w_idle   = (r_state == S_IDLE) && !reset;
  assign w_grant0 = w_idle && bus.r0_valid && (!bus.r1_valid || r_last_grant);
  assign w_grant1 = w_idle && bus.r1_valid && (!bus.r0_valid || !r_last_grant);
  assign w_accept = w_grant0 || w_grant1;

  assign w_chip = w_grant1 ? bus.r1_chip : bus.r0_chip;
  assign w_addr = w_grant1 ? bus.r1_addr : bus.r0_addr;
  assign w_data = w_grant1 ? bus.r1_data : bus.r0_data;

  // A flush on the acceptance edge counts as already applied to the cache.
  assign w_hit = r_cache_valid && !bus.flush &&
                 (r_cache_chip == w_chip) && (r_cache_addr == w_addr);

  assign w_cnt_done   = (r_cnt == 8'd0);
  assign w_cache_load = (r_state == S_ADDR) && w_cnt_done;

  assign bus.r0_ready  = w_grant0;
  assign bus.r1_ready  = w_grant1;
  assign bus.bdir      = r_bdir;
  assign bus.bc1       = r_bc1;
  assign bus.ym_da     = r_da;
  assign bus.da_oe     = r_oe;
  assign bus.ym_sel    = r_sel;
  assign bus.busy      = r_busy;
  assign bus.dbg_state = r_state;

  // Sequencer FSM: phase timing, request capture and registered bus outputs.
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_addr       <= 4'd0;
      r_data       <= 8'd0;
      r_last_grant <= 1'b1;
      r_bdir       <= 1'b0;
      r_bc1        <= 1'b0;
      r_da         <= 8'd0;
      r_oe         <= 1'b0;
      r_sel        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr       <= w_addr;
            r_data       <= w_data;
            r_sel        <= w_chip;
            r_last_grant <= w_grant1;
            r_busy       <= 1'b1;
            r_oe         <= 1'b1;
            r_bdir       <= 1'b1;
            r_cnt        <= PULSE_LD;
            if (w_hit) begin
              r_state <= S_DATA;
              r_bc1   <= 1'b0;
              r_da    <= w_data;
            end else begin
              r_state <= S_ADDR;
              r_bc1   <= 1'b1;
              r_da    <= {4'h0, w_addr};
            end
          end
        end
        S_ADDR: begin
          if (w_cnt_done) begin
            r_state <= S_GAP1;
            r_bdir  <= 1'b0;
            r_bc1   <= 1'b0;
            r_cnt   <= GAP_LD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_GAP1: begin
          if (w_cnt_done) begin
            r_state <= S_DATA;
            r_bdir  <= 1'b1;
            r_da    <= r_data;
            r_cnt   <= PULSE_LD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DATA: begin
          if (w_cnt_done) begin
            r_state <= S_GAP2;
            r_bdir  <= 1'b0;
            r_cnt   <= GAP_LD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_GAP2: begin
          if (w_cnt_done) begin
            r_state <= S_IDLE;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_bdir  <= 1'b0;
          r_bc1   <= 1'b0;
          r_oe    <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Address cache: remembers the last chip/register addressed; flush wins
  // over a load on the same edge.
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      r_cache_valid <= 1'b0;
      r_cache_chip  <= 1'b0;
      r_cache_addr  <= 4'd0;
    end else begin
      if (w_cache_load) begin
        r_cache_chip <= r_sel;
        r_cache_addr <= r_addr;
      end
      if (bus.flush) begin
        r_cache_valid <= 1'b0;
      end else if (w_cache_load) begin
        r_cache_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ym_bus_sequencer.sv
// Bench for ym_bus_sequencer: DUT A uses default timing, DUT B uses the
// shortest timing (1/1). Bus phases of DUT A are also checked by a monitor
// against an expected queue filled when each request is driven.
module tb_ym_bus_sequencer;

  localparam int W = 18; // {bc1, ym_sel, ym_da[7:0], pulse_len[7:0]}

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  ym_bus_sequencer_if bus_a ();
  ym_bus_sequencer_if bus_b ();

  ym_bus_sequencer #(.PULSE_CYC(4), .GAP_CYC(2)) dut_a (
    .cpu_clock (clk),
    .reset     (rst_a),
    .bus       (bus_a)
  );

  ym_bus_sequencer #(.PULSE_CYC(1), .GAP_CYC(1)) dut_b (
    .cpu_clock (clk),
    .reset     (rst_b),
    .bus       (bus_b)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus-phase monitor on DUT A: one entry per bdir pulse
  logic         mon_act = 1'b0;
  logic [7:0]   mon_len = 8'd0;
  logic [9:0]   mon_hdr = 10'd0;
  logic [W-1:0] mon_exp;

  always @(negedge clk) begin
    if (rst_a) begin
      mon_act = 1'b0;
    end else if (bus_a.bdir) begin
      if (!mon_act) begin
        mon_act = 1'b1;
        mon_len = 8'd1;
        mon_hdr = {bus_a.bc1, bus_a.ym_sel, bus_a.ym_da};
      end else begin
        mon_len = mon_len + 8'd1;
        checks++;
        if ({bus_a.bc1, bus_a.ym_sel, bus_a.ym_da} !== mon_hdr) begin
          failures++;
          $display("FAIL phase_stable: got %h, required %h",
                   {bus_a.bc1, bus_a.ym_sel, bus_a.ym_da}, mon_hdr);
        end
      end
    end else if (mon_act) begin
      mon_act = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL bus_phase: unexpected phase %h", {mon_hdr, mon_len});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mon_hdr, mon_len} !== mon_exp) begin
          failures++;
          $display("FAIL bus_phase: got %h, required %h", {mon_hdr, mon_len}, mon_exp);
        end
      end
    end
  end

  // Driver tasks
  task automatic drive_req(input bit sel, input bit req, input bit v,
                           input bit chip, input logic [3:0] addr,
                           input logic [7:0] data);
    if (!sel) begin
      if (!req) begin
        bus_a.r0_valid = v; bus_a.r0_chip = chip; bus_a.r0_addr = addr; bus_a.r0_data = data;
      end else begin
        bus_a.r1_valid = v; bus_a.r1_chip = chip; bus_a.r1_addr = addr; bus_a.r1_data = data;
      end
    end else begin
      if (!req) begin
        bus_b.r0_valid = v; bus_b.r0_chip = chip; bus_b.r0_addr = addr; bus_b.r0_data = data;
      end else begin
        bus_b.r1_valid = v; bus_b.r1_chip = chip; bus_b.r1_addr = addr; bus_b.r1_data = data;
      end
    end
  endtask

  task automatic drive_flush(input bit sel, input bit v);
    if (!sel) bus_a.flush = v;
    else      bus_b.flush = v;
  endtask

  function automatic logic [5:0] obs_ctl(input bit sel);
    if (!sel) return {bus_a.bdir, bus_a.bc1, bus_a.da_oe, bus_a.busy, bus_a.r0_ready, bus_a.r1_ready};
    return {bus_b.bdir, bus_b.bc1, bus_b.da_oe, bus_b.busy, bus_b.r0_ready, bus_b.r1_ready};
  endfunction

  function automatic logic [8:0] obs_bus(input bit sel);
    if (!sel) return {bus_a.ym_sel, bus_a.ym_da};
    return {bus_b.ym_sel, bus_b.ym_da};
  endfunction

  function automatic logic obs_ready(input bit sel, input bit req);
    if (!sel) return req ? bus_a.r1_ready : bus_a.r0_ready;
    return req ? bus_b.r1_ready : bus_b.r0_ready;
  endfunction

  // Reference timing: {bdir, bc1, da_oe, busy, data_phase} for cycle c after acceptance
  function automatic logic [4:0] exp_phase(input int c, input int p, input int g, input bit hit);
    int d0;
    d0 = hit ? 1 : p + g + 1;
    if (!hit && c >= 1 && c <= p) return 5'b11110;
    if (!hit && c > p && c <= p + g) return 5'b00110;
    if (c >= d0 && c < d0 + p) return 5'b10111;
    if (c >= d0 + p && c < d0 + p + g) return 5'b00111;
    return 5'b00000;
  endfunction

  // One complete write, checked every cycle until the first idle cycle.
  // Must be entered between a falling edge and the next rising edge.
  task automatic xfer(input bit sel, input bit req, input bit chip,
                      input logic [3:0] addr, input logic [7:0] data,
                      input bit hit, input int flush_cyc, input int glitch_cyc);
    int p, g, n;
    logic [4:0] e;
    logic [5:0] o;
    logic [7:0] eda;
    p = sel ? 1 : 4;
    g = sel ? 1 : 2;
    n = hit ? (p + g) : (2 * p + 2 * g);
    if (!sel) begin
      if (!hit) exp_q.push_back({1'b1, chip, 4'h0, addr, 8'(p)});
      exp_q.push_back({1'b0, chip, data, 8'(p)});
    end
    drive_req(sel, req, 1'b1, chip, addr, data);
    drive_flush(sel, flush_cyc == 0);
    #1;
    checks++;
    if (obs_ready(sel, req) !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready dut=%0d req=%0d: got %b, required 1", sel, req, obs_ready(sel, req));
    end
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      drive_req(sel, req, 1'b0, chip, addr, data);
      drive_req(sel, !req, c == glitch_cyc, chip, addr, data);
      drive_flush(sel, c == flush_cyc);
      #1;
      e = exp_phase(c, p, g, hit);
      o = obs_ctl(sel);
      checks++;
      if (o !== {e[4:1], 2'b00}) begin
        failures++;
        $display("FAIL ctl dut=%0d addr=%h cycle=%0d: got %b, required %b", sel, addr, c, o, {e[4:1], 2'b00});
      end
      if (e[2]) begin
        eda = e[0] ? data : {4'h0, addr};
        checks++;
        if (obs_bus(sel) !== {chip, eda}) begin
          failures++;
          $display("FAIL bus_value dut=%0d cycle=%0d: got %h, required %h", sel, c, obs_bus(sel), {chip, eda});
        end
      end
    end
  endtask

  task automatic pulse_reset_a;
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    #1 rst_a = 1'b0;
  endtask

  // Tests
  task automatic test_reset;
    drive_req(0, 0, 1'b1, 1'b1, 4'hA, 8'hAA);
    drive_req(0, 1, 1'b1, 1'b1, 4'hB, 8'hBB);
    drive_req(1, 0, 1'b1, 1'b1, 4'hA, 8'hAA);
    drive_req(1, 1, 1'b1, 1'b1, 4'hB, 8'hBB);
    drive_flush(0, 1'b0);
    drive_flush(1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({obs_ctl(0), obs_bus(0)} !== 15'd0) begin
      failures++;
      $display("FAIL reset_a: got %h, required 0", {obs_ctl(0), obs_bus(0)});
    end
    checks++;
    if ({obs_ctl(1), obs_bus(1)} !== 15'd0) begin
      failures++;
      $display("FAIL reset_b: got %h, required 0", {obs_ctl(1), obs_bus(1)});
    end
    drive_req(0, 0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive_req(0, 1, 1'b0, 1'b0, 4'h0, 8'h00);
    drive_req(1, 0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive_req(1, 1, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  // Runs right after reset release: accepted on the first edge after reset falls.
  task automatic test_first_write;
    xfer(0, 0, 1'b0, 4'h7, 8'h38, 1'b0, -1, -1);
  endtask

  // Cache hit; requester 1 pulses valid mid-transfer and must not be remembered.
  task automatic test_cached_write;
    @(negedge clk);
    xfer(0, 0, 1'b0, 4'h7, 8'h3F, 1'b1, -1, 3);
  endtask

  task automatic test_reset_mid_data;
    @(negedge clk);
    exp_q.push_back({1'b1, 1'b0, 8'h05, 8'd4});
    drive_req(0, 0, 1'b1, 1'b0, 4'h5, 8'h55);
    #1;
    checks++;
    if (bus_a.r0_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_accept: got %b, required 1", bus_a.r0_ready);
    end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      drive_req(0, 0, 1'b0, 1'b0, 4'h5, 8'h55);
    end
    #1;
    checks++;
    if ({bus_a.bdir, bus_a.bc1, bus_a.da_oe} !== 3'b101) begin
      failures++;
      $display("FAIL rst_mid_in_data: got %b, required 101", {bus_a.bdir, bus_a.bc1, bus_a.da_oe});
    end
    rst_a = 1'b1;
    #1;
    checks++;
    if ({bus_a.bdir, bus_a.bc1, bus_a.da_oe, bus_a.busy} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_async: got %b, required 0000", {bus_a.bdir, bus_a.bc1, bus_a.da_oe, bus_a.busy});
    end
    @(negedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    xfer(0, 0, 1'b0, 4'h5, 8'h56, 1'b0, -1, -1);
  endtask

  task automatic test_flush;
    @(negedge clk);
    xfer(0, 1, 1'b1, 4'h3, 8'h33, 1'b0, 11, -1); // flush in GAP2
    @(negedge clk);
    xfer(0, 1, 1'b1, 4'h3, 8'h34, 1'b0, 4, -1);  // flush on the cache-load edge
    @(negedge clk);
    xfer(0, 1, 1'b1, 4'h3, 8'h35, 1'b0, -1, -1); // still a miss, loads cache
    @(negedge clk);
    xfer(0, 1, 1'b1, 4'h3, 8'h36, 1'b1, -1, -1); // hit
    @(negedge clk);
    xfer(0, 0, 1'b1, 4'h3, 8'h37, 1'b0, 0, -1);  // flush on the acceptance edge
  endtask

  // Both requesters held valid: alternating grants, back-to-back spacing.
  task automatic test_round_robin;
    bit w;
    pulse_reset_a();
    @(negedge clk);
    drive_req(0, 0, 1'b1, 1'b0, 4'h1, 8'hA0);
    drive_req(0, 1, 1'b1, 1'b1, 4'h2, 8'hB1);
    for (int i = 0; i < 4; i++) begin
      w = i[0];
      #1;
      checks++;
      if ({bus_a.r1_ready, bus_a.r0_ready} !== (w ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rr_grant %0d: got %b, required %b", i, {bus_a.r1_ready, bus_a.r0_ready}, w ? 2'b10 : 2'b01);
      end
      if (w) begin
        exp_q.push_back({1'b1, 1'b1, 8'h02, 8'd4});
        exp_q.push_back({1'b0, 1'b1, 8'hB1, 8'd4});
      end else begin
        exp_q.push_back({1'b1, 1'b0, 8'h01, 8'd4});
        exp_q.push_back({1'b0, 1'b0, 8'hA0, 8'd4});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({bus_a.bdir, bus_a.bc1, bus_a.ym_sel} !== {2'b11, w}) begin
        failures++;
        $display("FAIL rr_sel %0d: got %b, required %b", i, {bus_a.bdir, bus_a.bc1, bus_a.ym_sel}, {2'b11, w});
      end
      repeat (12) @(negedge clk);
    end
    #1;
    checks++;
    if ({bus_a.r1_ready, bus_a.r0_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rr_grant 4: got %b, required 01", {bus_a.r1_ready, bus_a.r0_ready});
    end
    drive_req(0, 0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive_req(0, 1, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    #1;
    checks++;
    if ({bus_a.busy, bus_a.da_oe} !== 2'b00) begin
      failures++;
      $display("FAIL rr_stop: got %b, required 00", {bus_a.busy, bus_a.da_oe});
    end
  endtask

  task automatic test_short_params;
    @(negedge clk);
    xfer(1, 0, 1'b0, 4'h9, 8'h99, 1'b0, -1, -1);
    @(negedge clk);
    xfer(1, 0, 1'b0, 4'h9, 8'h9A, 1'b1, -1, -1);
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_first_write();
    test_cached_write();
    test_reset_mid_data();
    test_flush();
    test_round_robin();
    test_short_params();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL exp_q_drained: got %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
